// File: rtl/pet_pkg.sv
// rtl/pet_pkg.sv - life-state encodings and saturating arithmetic shared by the pet stats engine.
package pet_pkg;

  typedef enum logic [1:0] {
    LIFE_ALIVE = 2'd0,
    LIFE_SICK  = 2'd1,
    LIFE_DEAD  = 2'd2,
    LIFE_SLEEP = 2'd3
  } life_e;

  // Helpers operate on a 16-bit carrier; callers zero-extend their stat width into it.
  localparam int SAT_W = 16;
  typedef logic [SAT_W-1:0] sat_t;

  function automatic sat_t sat_add(input sat_t a, input sat_t b, input sat_t max);
    logic [SAT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[SAT_W-1:0];
  endfunction

  function automatic sat_t sat_sub(input sat_t a, input sat_t b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/pet_stats_engine_if.sv
// rtl/pet_stats_engine_if.sv - valid/ready action port of the pet stats engine.
interface pet_stats_engine_if #(
  parameter int NUM_STATS = 6,
  parameter int STAT_W    = 4
);
  localparam int IDX_W = $clog2(NUM_STATS);

  logic              action_valid;
  logic              action_ready;
  logic [IDX_W-1:0]  action_idx;
  logic [STAT_W-1:0] action_amt;

  modport master (
    output action_valid, action_idx, action_amt,
    input  action_ready
  );

  modport slave (
    input  action_valid, action_idx, action_amt,
    output action_ready
  );
endinterface

// File: rtl/pet_tick_gen.sv
// rtl/pet_tick_gen.sv - free-running decay tick divider; one-cycle pulse every TICK_COUNT cycles.
module pet_tick_gen #(
  parameter int TICK_COUNT = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int            CNT_W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_COUNT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == LAST);
endmodule

// File: rtl/pet_stats_engine.sv
// rtl/pet_stats_engine.sv - NUM_STATS saturating pet stats with decay, action port and life FSM.
// Optional PET_SLEEP_EN adds the SLEEP state driven by the energy stat at ENERGY_IDX.
module pet_stats_engine
  import pet_pkg::*;
#(
  parameter int NUM_STATS   = 6,
  parameter int STAT_W      = 4,
  parameter int TICK_COUNT  = 10_000_000,
  parameter int SICK_THRESH = 3,
  parameter int DEAD_TICKS  = 4
`ifdef PET_SLEEP_EN
  ,
  parameter int ENERGY_IDX  = 4
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  pet_stats_engine_if.slave           act,
  output logic [NUM_STATS*STAT_W-1:0] stats_flat,
  output logic [1:0]                  life_state,
  output logic                        tick
);
  localparam int                IDX_W    = $clog2(NUM_STATS);
  localparam int                DC_W     = $clog2(DEAD_TICKS + 1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  localparam logic [STAT_W-1:0] SICK_T   = STAT_W'(SICK_THRESH);
  localparam logic [DC_W-1:0]   DEAD_T   = DC_W'(DEAD_TICKS);

  logic [STAT_W-1:0] r_stats      [NUM_STATS];
  logic [STAT_W-1:0] w_stats_next [NUM_STATS];
  life_e             r_state;
  life_e             w_state_next;
  logic [DC_W-1:0]   r_dead_cnt;
  logic [DC_W-1:0]   w_dead_next;
  logic              r_ready;
  logic              w_ready_next;
  logic              w_tick;
  logic              w_accept;
  logic              w_any_zero;
  logic              w_any_low;

  pet_tick_gen #(
    .TICK_COUNT(TICK_COUNT)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Out-of-range indices still complete the handshake; they just match no stat.
  assign w_accept = act.action_valid && r_ready && (int'(act.action_idx) < NUM_STATS);

  // Action is applied before decay so a same-cycle add and tick give sat_sub(sat_add(s, amt), 1).
  always_comb begin
    w_any_zero = 1'b0;
    w_any_low  = 1'b0;
    for (int i = 0; i < NUM_STATS; i++) begin
      w_stats_next[i] = r_stats[i];
      if (r_state != LIFE_DEAD) begin
        if (w_accept && (act.action_idx == IDX_W'(i))) begin
          w_stats_next[i] = STAT_W'(sat_add(sat_t'(w_stats_next[i]), sat_t'(act.action_amt),
                                            sat_t'(STAT_MAX)));
        end
        if (w_tick) begin
`ifdef PET_SLEEP_EN
          if (r_state == LIFE_SLEEP) begin
            if (i == ENERGY_IDX) begin
              w_stats_next[i] = STAT_W'(sat_add(sat_t'(w_stats_next[i]), sat_t'(1),
                                                sat_t'(STAT_MAX)));
            end
          end else begin
            w_stats_next[i] = STAT_W'(sat_sub(sat_t'(w_stats_next[i]), sat_t'(1)));
          end
`else
          w_stats_next[i] = STAT_W'(sat_sub(sat_t'(w_stats_next[i]), sat_t'(1)));
`endif
        end
      end
      if (w_stats_next[i] == '0) w_any_zero = 1'b1;
      if (w_stats_next[i] <= SICK_T) w_any_low = 1'b1;
    end
  end

  always_comb begin
    w_dead_next  = r_dead_cnt;
    w_state_next = r_state;
    case (r_state)
      LIFE_ALIVE, LIFE_SICK: begin
        if (w_tick) begin
          if (!w_any_zero) begin
            w_dead_next = '0;
          end else if (r_dead_cnt != DEAD_T) begin
            w_dead_next = r_dead_cnt + DC_W'(1);
          end
        end
        if (w_dead_next == DEAD_T) begin
          w_state_next = LIFE_DEAD;
`ifdef PET_SLEEP_EN
        end else if (w_stats_next[ENERGY_IDX] == '0) begin
          w_state_next = LIFE_SLEEP;
`endif
        end else if (w_any_low) begin
          w_state_next = LIFE_SICK;
        end else begin
          w_state_next = LIFE_ALIVE;
        end
      end
`ifdef PET_SLEEP_EN
      // Dead count is frozen while asleep; wake only on the tick that refills energy.
      LIFE_SLEEP: begin
        if (w_tick && (w_stats_next[ENERGY_IDX] == STAT_MAX)) begin
          w_state_next = w_any_low ? LIFE_SICK : LIFE_ALIVE;
        end
      end
`endif
      default: begin
        w_state_next = r_state;
      end
    endcase
  end

  assign w_ready_next = (w_state_next == LIFE_ALIVE) || (w_state_next == LIFE_SICK);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_STATS; i++) r_stats[i] <= STAT_MAX;
      r_state    <= LIFE_ALIVE;
      r_dead_cnt <= '0;
      r_ready    <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_STATS; i++) r_stats[i] <= w_stats_next[i];
      r_state    <= w_state_next;
      r_dead_cnt <= w_dead_next;
      r_ready    <= w_ready_next;
    end
  end

  for (genvar g = 0; g < NUM_STATS; g++) begin : g_flat
    assign stats_flat[g*STAT_W +: STAT_W] = r_stats[g];
  end

  assign act.action_ready = r_ready;
  assign life_state       = r_state;
  assign tick             = w_tick;
endmodule
